// File: rtl/xbar_route_fifo_param.sv
// rtl/xbar_route_fifo_param.sv - PE-to-accumulator crossbar with per-bank FIFOs
// Converts 1-based lane coordinates to 0-based and queues each packet in the bank picked by one coordinate.
module xbar_route_fifo_param #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_DST    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 16,
  parameter int CRD_W      = 8,
  parameter int ROUTE_MODE = 0
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      flush,
  input  logic [NUM_SRC-1:0]                        in_valid,
  input  logic [NUM_SRC*DATA_W-1:0]                 in_data,
  input  logic [NUM_SRC*CRD_W-1:0]                  in_row,
  input  logic [NUM_SRC*CRD_W-1:0]                  in_col,
  input  logic [NUM_SRC*CRD_W-1:0]                  in_k,
  output logic                                      busy,
  output logic [NUM_DST-1:0]                        out_valid,
  input  logic [NUM_DST-1:0]                        out_ready,
  output logic [NUM_DST*DATA_W-1:0]                 out_data,
  output logic [NUM_DST*CRD_W-1:0]                  out_x,
  output logic [NUM_DST*CRD_W-1:0]                  out_y,
  output logic [NUM_DST*CRD_W-1:0]                  out_k,
  output logic [NUM_DST*($clog2(FIFO_DEPTH)+1)-1:0] fifo_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(NUM_DST);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CRD_W-1:0]  x;
    logic [CRD_W-1:0]  y;
    logic [CRD_W-1:0]  k;
  } entry_t;

  entry_t          mem_q    [NUM_DST][FIFO_DEPTH];
  entry_t          mem_d    [NUM_DST][FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q [NUM_DST];
  logic [PW-1:0]   wr_ptr_d [NUM_DST];
  logic [PW-1:0]   rd_ptr_q [NUM_DST];
  logic [PW-1:0]   rd_ptr_d [NUM_DST];
  logic [CW-1:0]   cnt_q    [NUM_DST];
  logic [CW-1:0]   cnt_d    [NUM_DST];
  logic [CW-1:0]   push_n   [NUM_DST];
  logic [NUM_DST-1:0] pop;

  entry_t          lane_ent [NUM_SRC];
  logic [CRD_W-1:0] lane_sel [NUM_SRC];
  logic [DW-1:0]   lane_dst [NUM_SRC];
  entry_t          head     [NUM_DST];

  // Coordinate conversion wraps silently: a 0 input becomes all-ones.
  always_comb begin
    for (int l = 0; l < NUM_SRC; l++) begin
      lane_ent[l].data = in_data[l*DATA_W +: DATA_W];
      lane_ent[l].x    = in_col[l*CRD_W +: CRD_W] - CRD_W'(1);
      lane_ent[l].y    = in_row[l*CRD_W +: CRD_W] - CRD_W'(1);
      lane_ent[l].k    = in_k[l*CRD_W +: CRD_W] - CRD_W'(1);
      case (ROUTE_MODE)
        1:       lane_sel[l] = lane_ent[l].x;
        2:       lane_sel[l] = lane_ent[l].k;
        default: lane_sel[l] = lane_ent[l].y;
      endcase
      lane_dst[l] = lane_sel[l][DW-1:0];
    end
  end

  // Headroom of NUM_SRC entries lets every lane hit one bank without overflow.
  always_comb begin
    busy = 1'b0;
    for (int d = 0; d < NUM_DST; d++) begin
      if (cnt_q[d] > CW'(FIFO_DEPTH - NUM_SRC)) begin
        busy = 1'b1;
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int d = 0; d < NUM_DST; d++) begin
      push_n[d] = '0;
      pop[d]    = (cnt_q[d] != '0) && out_ready[d];
    end
    // Lanes sharing a bank land in consecutive slots, lowest lane first.
    if (!busy) begin
      for (int l = 0; l < NUM_SRC; l++) begin
        if (in_valid[l]) begin
          mem_d[lane_dst[l]][wr_ptr_q[lane_dst[l]] + push_n[lane_dst[l]][PW-1:0]] = lane_ent[l];
          push_n[lane_dst[l]] = push_n[lane_dst[l]] + CW'(1);
        end
      end
    end
    for (int d = 0; d < NUM_DST; d++) begin
      wr_ptr_d[d] = wr_ptr_q[d] + push_n[d][PW-1:0];
      if (pop[d]) begin
        rd_ptr_d[d] = rd_ptr_q[d] + PW'(1);
      end
      cnt_d[d] = cnt_q[d] + push_n[d] - CW'(pop[d]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int d = 0; d < NUM_DST; d++) begin
        wr_ptr_q[d] <= '0;
        rd_ptr_q[d] <= '0;
        cnt_q[d]    <= '0;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          mem_q[d][e] <= '0;
        end
      end
    end else if (flush) begin
      for (int d = 0; d < NUM_DST; d++) begin
        wr_ptr_q[d] <= '0;
        rd_ptr_q[d] <= '0;
        cnt_q[d]    <= '0;
      end
    end else begin
      for (int d = 0; d < NUM_DST; d++) begin
        wr_ptr_q[d] <= wr_ptr_d[d];
        rd_ptr_q[d] <= rd_ptr_d[d];
        cnt_q[d]    <= cnt_d[d];
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          mem_q[d][e] <= mem_d[d][e];
        end
      end
    end
  end

  // Outputs come straight from registered storage; a fresh push is never bypassed.
  always_comb begin
    for (int d = 0; d < NUM_DST; d++) begin
      head[d]                         = mem_q[d][rd_ptr_q[d]];
      out_valid[d]                    = (cnt_q[d] != '0);
      out_data[d*DATA_W +: DATA_W]    = head[d].data;
      out_x[d*CRD_W +: CRD_W]         = head[d].x;
      out_y[d*CRD_W +: CRD_W]         = head[d].y;
      out_k[d*CRD_W +: CRD_W]         = head[d].k;
      fifo_cnt[d*CW +: CW]            = cnt_q[d];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int d = 0; d < NUM_DST; d++) begin
        assert (cnt_q[d] <= CW'(FIFO_DEPTH));
      end
    end
  end

endmodule

// File: tb/tb_xbar_route_fifo_param.sv
// tb/tb_xbar_route_fifo_param.sv - bench for xbar_route_fifo_param
// Directed scenarios plus randomized traffic against a queue-based bank model.
module tb_xbar_route_fifo_param;

  localparam int NS    = 4;
  localparam int ND    = 4;
  localparam int DEPTH = 8;
  localparam int DWID  = 16;
  localparam int CRD   = 8;
  localparam int CNTW  = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               flush;
  logic [NS-1:0]      in_valid;
  logic [NS*DWID-1:0] in_data;
  logic [NS*CRD-1:0]  in_row;
  logic [NS*CRD-1:0]  in_col;
  logic [NS*CRD-1:0]  in_k;
  logic               busy;
  logic [ND-1:0]      out_valid;
  logic [ND-1:0]      out_ready;
  logic [ND*DWID-1:0] out_data;
  logic [ND*CRD-1:0]  out_x;
  logic [ND*CRD-1:0]  out_y;
  logic [ND*CRD-1:0]  out_k;
  logic [ND*CNTW-1:0] fifo_cnt;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic [DWID-1:0] data;
    logic [CRD-1:0]  x;
    logic [CRD-1:0]  y;
    logic [CRD-1:0]  k;
  } pkt_t;

  pkt_t mq [ND][$];

  xbar_route_fifo_param #(
    .NUM_SRC(NS), .NUM_DST(ND), .FIFO_DEPTH(DEPTH),
    .DATA_W(DWID), .CRD_W(CRD), .ROUTE_MODE(0)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_row(in_row), .in_col(in_col), .in_k(in_k),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_k(out_k),
    .fifo_cnt(fifo_cnt)
  );

  always #5 clock = ~clock;

  function automatic bit model_busy();
    for (int d = 0; d < ND; d++)
      if (mq[d].size() > DEPTH - NS) return 1'b1;
    return 1'b0;
  endfunction

  // Applies one clock edge worth of behaviour to the bank queues.
  task automatic model_edge();
    bit   pops [ND];
    bit   acc;
    pkt_t p;
    int   dst;
    if (reset || flush) begin
      for (int d = 0; d < ND; d++) mq[d].delete();
      return;
    end
    acc = !model_busy();
    for (int d = 0; d < ND; d++) pops[d] = (mq[d].size() != 0) && out_ready[d];
    if (acc) begin
      for (int l = 0; l < NS; l++) begin
        if (in_valid[l]) begin
          p.data = in_data[l*DWID +: DWID];
          p.x    = in_col[l*CRD +: CRD] - 8'd1;
          p.y    = in_row[l*CRD +: CRD] - 8'd1;
          p.k    = in_k[l*CRD +: CRD] - 8'd1;
          dst    = int'(p.y) % ND;
          mq[dst].push_back(p);
        end
      end
    end
    for (int d = 0; d < ND; d++) if (pops[d]) void'(mq[d].pop_front());
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lane(input int l, input int row, input int col, input int k, input int data);
    in_row[l*CRD +: CRD]    = CRD'(row);
    in_col[l*CRD +: CRD]    = CRD'(col);
    in_k[l*CRD +: CRD]      = CRD'(k);
    in_data[l*DWID +: DWID] = DWID'(data);
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = '1;
    for (int i = 0; i < 12; i++) tick();
    out_ready = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = '0; out_ready = '0;
    in_data = '0; in_row = '0; in_col = '0; in_k = '0;
    tick();
    tick();
    n_checks++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (fifo_cnt !== '0) begin n_err++; $display("FAIL reset_cnt got=%h exp=0", fifo_cnt); end
    n_checks++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", out_data); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    out_ready = '0;
    set_lane(0, 3, 5, 2, 16'h1234);
    in_valid = 4'b0001;
    tick();
    in_valid = '0;
    n_checks++; if (out_valid !== 4'b0100) begin n_err++; $display("FAIL single_valid got=%b exp=0100", out_valid); end
    n_checks++; if (out_y[2*CRD +: CRD] !== 8'd2) begin n_err++; $display("FAIL single_y got=%0d exp=2", out_y[2*CRD +: CRD]); end
    n_checks++; if (out_x[2*CRD +: CRD] !== 8'd4) begin n_err++; $display("FAIL single_x got=%0d exp=4", out_x[2*CRD +: CRD]); end
    n_checks++; if (out_k[2*CRD +: CRD] !== 8'd1) begin n_err++; $display("FAIL single_k got=%0d exp=1", out_k[2*CRD +: CRD]); end
    n_checks++; if (out_data[2*DWID +: DWID] !== 16'h1234) begin n_err++; $display("FAIL single_data got=%h exp=1234", out_data[2*DWID +: DWID]); end
    n_checks++; if (fifo_cnt[2*CNTW +: CNTW] !== 4'd1) begin n_err++; $display("FAIL single_cnt got=%0d exp=1", fifo_cnt[2*CNTW +: CNTW]); end
    drain();
  endtask

  task automatic test_fanin();
    out_ready = '1;
    for (int l = 0; l < NS; l++) set_lane(l, 1, $urandom_range(1, 200), $urandom_range(1, 200), 10 + l);
    in_valid = 4'b1111;
    tick();
    in_valid = '0;
    n_checks++; if (fifo_cnt[0 +: CNTW] !== 4'd4) begin n_err++; $display("FAIL fanin_cnt got=%0d exp=4", fifo_cnt[0 +: CNTW]); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid[0] !== 1'b1 || out_data[0 +: DWID] !== 16'(10 + i)) begin
        n_err++; $display("FAIL fanin_pop%0d got=%0d/%b exp=%0d/1", i, out_data[0 +: DWID], out_valid[0], 10 + i);
      end
      tick();
    end
    n_checks++; if (fifo_cnt[0 +: CNTW] !== 4'd0) begin n_err++; $display("FAIL fanin_empty got=%0d exp=0", fifo_cnt[0 +: CNTW]); end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = '0;
    for (int l = 0; l < NS; l++) set_lane(l, 1, 1, 1, 100 + l);
    in_valid = 4'b1111;
    tick();
    n_checks++; if (fifo_cnt[0 +: CNTW] !== 4'd4 || busy !== 1'b0) begin n_err++; $display("FAIL bp_first got=%0d/%b exp=4/0", fifo_cnt[0 +: CNTW], busy); end
    for (int l = 0; l < NS; l++) set_lane(l, 1, 1, 1, 104 + l);
    tick();
    n_checks++; if (fifo_cnt[0 +: CNTW] !== 4'd8 || busy !== 1'b1) begin n_err++; $display("FAIL bp_full got=%0d/%b exp=8/1", fifo_cnt[0 +: CNTW], busy); end
    for (int l = 0; l < NS; l++) set_lane(l, 1, 1, 1, 200 + l);
    tick();
    in_valid = '0;
    n_checks++; if (fifo_cnt[0 +: CNTW] !== 4'd8) begin n_err++; $display("FAIL bp_ignored got=%0d exp=8", fifo_cnt[0 +: CNTW]); end
    out_ready = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (out_data[0 +: DWID] !== 16'(100 + i)) begin n_err++; $display("FAIL bp_order%0d got=%0d exp=%0d", i, out_data[0 +: DWID], 100 + i); end
      tick();
      n_checks++;
      if (fifo_cnt[0 +: CNTW] !== 4'(7 - i) || busy !== ((7 - i) > DEPTH - NS)) begin
        n_err++; $display("FAIL bp_drain%0d got=%0d/%b exp=%0d/%b", i, fifo_cnt[0 +: CNTW], busy, 7 - i, (7 - i) > DEPTH - NS);
      end
    end
    drain();
  endtask

  task automatic test_push_pop();
    out_ready = '0;
    set_lane(2, 2, 9, 9, 16'hAAAA);
    in_valid = 4'b0100;
    tick();
    n_checks++; if (fifo_cnt[1*CNTW +: CNTW] !== 4'd1) begin n_err++; $display("FAIL pp_setup got=%0d exp=1", fifo_cnt[1*CNTW +: CNTW]); end
    set_lane(0, 2, 3, 3, 16'hBBBB);
    in_valid  = 4'b0001;
    out_ready = 4'b0010;
    tick();
    in_valid  = '0;
    out_ready = '0;
    n_checks++; if (fifo_cnt[1*CNTW +: CNTW] !== 4'd1) begin n_err++; $display("FAIL pp_cnt got=%0d exp=1", fifo_cnt[1*CNTW +: CNTW]); end
    n_checks++; if (out_data[1*DWID +: DWID] !== 16'hBBBB || out_valid[1] !== 1'b1) begin n_err++; $display("FAIL pp_head got=%h/%b exp=bbbb/1", out_data[1*DWID +: DWID], out_valid[1]); end
    drain();
  endtask

  task automatic test_wrap_flush();
    int sent [$];
    int pushed = 0;
    int popped = 0;
    int lane;
    int cyc = 0;
    logic [15:0] d;
    while (popped < 20 && cyc < 400) begin
      in_valid  = '0;
      out_ready = 4'($urandom_range(0, 1) << 3);
      if (out_valid[3] && out_ready[3]) begin
        n_checks++;
        if (sent.size() == 0) begin
          n_err++; $display("FAIL wrap_spurious got=%h exp=none", out_data[3*DWID +: DWID]);
        end else begin
          if (out_data[3*DWID +: DWID] !== 16'(sent[0])) begin n_err++; $display("FAIL wrap_order%0d got=%h exp=%h", popped, out_data[3*DWID +: DWID], sent[0]); end
          void'(sent.pop_front());
        end
        popped++;
      end
      if (pushed < 20 && $urandom_range(0, 3) != 0) begin
        lane = $urandom_range(0, NS - 1);
        d    = 16'($urandom);
        set_lane(lane, 4, $urandom_range(1, 255), $urandom_range(1, 255), d);
        in_valid[lane] = 1'b1;
        if (!model_busy()) begin
          sent.push_back(d);
          pushed++;
        end
      end
      tick();
      cyc++;
    end
    n_checks++; if (popped != 20) begin n_err++; $display("FAIL wrap_timeout got=%0d exp=20", popped); end
    out_ready = '0;
    for (int l = 0; l < 3; l++) set_lane(l, 4, 1, 1, 16'h0300 + l);
    in_valid = 4'b0111;
    tick();
    in_valid = '0;
    n_checks++; if (fifo_cnt[3*CNTW +: CNTW] !== 4'd3) begin n_err++; $display("FAIL flush_setup got=%0d exp=3", fifo_cnt[3*CNTW +: CNTW]); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (fifo_cnt[3*CNTW +: CNTW] !== 4'd0 || out_valid[3] !== 1'b0) begin n_err++; $display("FAIL flush_clear got=%0d/%b exp=0/0", fifo_cnt[3*CNTW +: CNTW], out_valid[3]); end
  endtask

  task automatic test_random();
    pkt_t h;
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < NS; l++)
        set_lane(l, $urandom_range(0, 12), $urandom_range(0, 255), $urandom_range(0, 255), $urandom);
      in_valid  = 4'($urandom);
      out_ready = 4'($urandom);
      flush     = ($urandom_range(0, 59) == 0);
      tick();
      n_checks++; if (busy !== model_busy()) begin n_err++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, busy, model_busy()); end
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (fifo_cnt[d*CNTW +: CNTW] !== 4'(mq[d].size()) || out_valid[d] !== (mq[d].size() != 0)) begin
          n_err++; $display("FAIL rand_cnt c=%0d b=%0d got=%0d/%b exp=%0d", c, d, fifo_cnt[d*CNTW +: CNTW], out_valid[d], mq[d].size());
        end
        if (mq[d].size() != 0) begin
          h = mq[d][0];
          n_checks++;
          if ({out_data[d*DWID +: DWID], out_x[d*CRD +: CRD], out_y[d*CRD +: CRD], out_k[d*CRD +: CRD]} !== h) begin
            n_err++; $display("FAIL rand_head c=%0d b=%0d got=%h%h%h%h exp=%h", c, d, out_data[d*DWID +: DWID], out_x[d*CRD +: CRD], out_y[d*CRD +: CRD], out_k[d*CRD +: CRD], h);
          end
        end
      end
    end
    flush = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fanin();
    test_backpressure();
    test_push_pop();
    test_wrap_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
